// File: rtl/decoder_1bit_pkg.sv
// Shared constants and the reference one-hot decode for the 1-to-2 line decoder.
package decoder_1bit_pkg;

    localparam logic SEL_LINE0 = 1'b0;
    localparam logic SEL_LINE1 = 1'b1;

    // Returns {out2, out1}; a two-state argument always yields a one-hot result.
    function automatic logic [1:0] decode1(input bit s);
        return {s == SEL_LINE1, s == SEL_LINE0};
    endfunction

endpackage

// File: rtl/decoder_1bit_toggle_cnt.sv
// Saturating counter of select-bit changes, seen as differences against a one-cycle-old copy.
module decoder_1bit_toggle_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic in_q;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= 1'b0;
            cnt  <= '0;
        end else begin
            in_q <= in;
            if ((in != in_q) && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/decoder_1bit.sv
// 1-to-2 line decoder with a select-toggle counter.
// Define DECODER_1BIT_REG_OUT_EN to register out1/out2 (one cycle of latency, reset to all-zero).
module decoder_1bit
    import decoder_1bit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    output logic             out1,
    output logic             out2,
    output logic [CNT_W-1:0] toggle_cnt
);

    // Equality against the line constants keeps an X/Z select visible on both outputs.
`ifdef DECODER_1BIT_REG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1 <= 1'b0;
            out2 <= 1'b0;
        end else begin
            out1 <= (in == SEL_LINE0);
            out2 <= (in == SEL_LINE1);
        end
    end
`else
    assign out1 = (in == SEL_LINE0);
    assign out2 = (in == SEL_LINE1);
`endif

    decoder_1bit_toggle_cnt #(
        .CNT_W (CNT_W)
    ) u_toggle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .cnt   (toggle_cnt)
    );

endmodule

// File: tb/tb_decoder_1bit.sv
// Self-checking bench for decoder_1bit; covers both builds (DECODER_1BIT_REG_OUT_EN on/off).
module tb_decoder_1bit;
    import decoder_1bit_pkg::*;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n;
    logic       in;
    logic       out1, out2;
    logic [7:0] cnt8;
    logic       out1_b, out2_b;
    logic [1:0] cnt2;

    int          tests = 0;
    int          fails = 0;
    int unsigned m_changes;
    bit          m_prev;
    logic [1:0]  m_reg;

    always #5 if (clk_en) clk = ~clk;

    decoder_1bit #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(in),
        .out1(out1), .out2(out2), .toggle_cnt(cnt8)
    );

    decoder_1bit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in(in),
        .out1(out1_b), .out2(out2_b), .toggle_cnt(cnt2)
    );

    function automatic int unsigned sat(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [1:0] exp_out();
`ifdef DECODER_1BIT_REG_OUT_EN
        return m_reg;
`else
        return decode1(in);
`endif
    endfunction

    // Advance one clock; the model takes the select value present at the edge.
    task automatic tick();
        bit s;
        s = in;
        @(posedge clk);
        if (rst_n) begin
            if (s != m_prev) m_changes++;
            m_prev = s;
            m_reg  = decode1(s);
        end
        #1;
    endtask

    task automatic assert_reset();
        rst_n     = 1'b0;
        m_changes = 0;
        m_prev    = 1'b0;
        m_reg     = 2'b00;
        #1;
    endtask

    task automatic check_counts(input string name);
        tests++;
        if (cnt8 !== 8'(sat(m_changes, 255))) begin
            fails++;
            $display("FAIL %s cnt8: got %0d expected %0d", name, cnt8, sat(m_changes, 255));
        end
        tests++;
        if (cnt2 !== 2'(sat(m_changes, 3))) begin
            fails++;
            $display("FAIL %s cnt2: got %0d expected %0d", name, cnt2, sat(m_changes, 3));
        end
    endtask

    task automatic check_outs(input string name);
        tests++;
        if ({out2, out1} !== exp_out() || {out2_b, out1_b} !== exp_out()) begin
            fails++;
            $display("FAIL %s outs: got {out2,out1}=%b/%b expected %b",
                     name, {out2, out1}, {out2_b, out1_b}, exp_out());
        end
    endtask

    task automatic test_comb();
        in = 1'b0;
        assert_reset();
        check_outs("t0_in0");
`ifndef DECODER_1BIT_REG_OUT_EN
        tests++;
        if (out1 !== 1'b1 || out2 !== 1'b0) begin
            fails++;
            $display("FAIL t0_literal: got out1=%b out2=%b expected 1 0", out1, out2);
        end
`endif
        #9;
        in = 1'b1;
        #1;
        check_outs("t10_in1");
`ifdef DECODER_1BIT_REG_OUT_EN
        tests++;
        if (out1 !== 1'b0 || out2 !== 1'b0) begin
            fails++;
            $display("FAIL reg_reset_zero: got out1=%b out2=%b expected 0 0", out1, out2);
        end
`else
        tests++;
        if (out1 !== 1'b0 || out2 !== 1'b1) begin
            fails++;
            $display("FAIL t10_literal: got out1=%b out2=%b expected 0 1", out1, out2);
        end
`endif
        check_counts("comb_cnt");
    endtask

    task automatic test_reset();
        in    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in = ~in;
            tick();
        end
        check_counts("pre_reset_cnt");
        #2;
        assert_reset();
        check_counts("async_reset_cnt");
        check_outs("async_reset_outs_a");
        in = ~in;
        #1;
        check_outs("async_reset_outs_b");
        tick();
        check_counts("held_reset_cnt");
    endtask

    task automatic test_toggle_count();
        in = 1'b0;
        assert_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in = ~in;
            tick();
        end
        tests++;
        if (cnt8 !== 8'd5) begin
            fails++;
            $display("FAIL toggle5: got %0d expected 5", cnt8);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (cnt8 !== 8'd5) begin
                fails++;
                $display("FAIL hold_cnt: got %0d expected 5", cnt8);
            end
        end
        check_outs("toggle_outs");
    endtask

    task automatic test_saturation();
        in = 1'b0;
        assert_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in = ~in;
            tick();
            check_counts("sat_step");
        end
        tests++;
        if (cnt2 !== 2'd3) begin
            fails++;
            $display("FAIL sat_cnt2: got %0d expected 3", cnt2);
        end
    endtask

`ifdef DECODER_1BIT_REG_OUT_EN
    task automatic test_reg_out();
        in = 1'b1;
        assert_reset();
        tests++;
        if ({out2, out1} !== 2'b00) begin
            fails++;
            $display("FAIL reg_in_reset: got %b expected 00", {out2, out1});
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if ({out2, out1} !== 2'b00) begin
            fails++;
            $display("FAIL reg_pre_edge: got %b expected 00", {out2, out1});
        end
        tick();
        tests++;
        if (out2 !== 1'b1 || out1 !== 1'b0) begin
            fails++;
            $display("FAIL reg_first_edge: got %b expected 10", {out2, out1});
        end
        in = 1'b0;
        #1;
        tests++;
        if (out1 !== 1'b0) begin
            fails++;
            $display("FAIL reg_latency: got out1=%b expected 0 before edge", out1);
        end
        tick();
        tests++;
        if (out1 !== 1'b1 || out2 !== 1'b0) begin
            fails++;
            $display("FAIL reg_follow: got %b expected 01", {out2, out1});
        end
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        in = 1'b0;
        assert_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                assert_reset();
                #1;
                rst_n = 1'b1;
            end
            tick();
            tests++;
            if ({out2, out1} !== exp_out() || cnt8 !== 8'(sat(m_changes, 255)) ||
                cnt2 !== 2'(sat(m_changes, 3)) ||
                (exp_out() != 2'b00 && (out1 ^ out2) !== 1'b1)) begin
                fails++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random cycle %0d: got outs=%b cnt8=%0d cnt2=%0d expected outs=%b cnt=%0d",
                             i, {out2, out1}, cnt8, cnt2, exp_out(), m_changes);
            end
        end
    endtask

    initial begin
        test_comb();
        clk_en = 1'b1;
        test_reset();
        test_toggle_count();
        test_saturation();
`ifdef DECODER_1BIT_REG_OUT_EN
        test_reg_out();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
